// File: rtl/ic_irq_servicer.sv
// CPU-side interrupt consumer: captures the active ID, runs a fixed-length
// service routine, acknowledges it, and tracks preemption and service statistics.
module ic_irq_servicer #(
    parameter int SVC_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             irq_out,
    input  logic [2:0]       irq_id,
    input  logic             clr_stats,
    output logic             ack,
    output logic             busy,
    output logic [2:0]       cur_id,
    output logic [2:0]       last_id,
    output logic [CNT_W-1:0] serviced_cnt,
    output logic [CNT_W-1:0] preempt_cnt,
    output logic [CNT_W-1:0] spurious_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVICE = 2'd1,
        ACK_ST  = 2'd2
    } state_e;

    localparam logic [7:0] RELOAD = 8'(SVC_CYCLES - 1);

    state_e           state_q, state_d;
    logic [7:0]       svc_q, svc_d;
    logic [2:0]       cur_q, cur_d;
    logic [2:0]       last_q, last_d;
    logic [CNT_W-1:0] srv_q, pre_q, spu_q;
    logic             inc_srv, inc_pre, inc_spu;
    logic             id_match;

    assign id_match = (irq_id == cur_q);

    always_comb begin
        state_d = state_q;
        svc_d   = svc_q;
        cur_d   = cur_q;
        last_d  = last_q;
        inc_srv = 1'b0;
        inc_pre = 1'b0;
        inc_spu = 1'b0;
        ack     = (state_q == ACK_ST) && irq_out && id_match;
        case (state_q)
            IDLE: begin
                if (en && irq_out) begin
                    cur_d   = irq_id;
                    svc_d   = RELOAD;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (!irq_out) begin
                    inc_spu = 1'b1;
                    state_d = IDLE;
                end else if (!id_match) begin
                    inc_pre = (irq_id < cur_q);
                    inc_spu = (irq_id > cur_q);
                    cur_d   = irq_id;
                    svc_d   = RELOAD;
                end else if (svc_q == 8'd0) begin
                    state_d = ACK_ST;
                end else begin
                    svc_d = svc_q - 8'd1;
                end
            end
            ACK_ST: begin
                if (ack) begin
                    inc_srv = 1'b1;
                    last_d  = cur_q;
                    state_d = IDLE;
                end else if (!irq_out) begin
                    inc_spu = 1'b1;
                    state_d = IDLE;
                end else begin
                    // Controller now presents a different ID: restart service on it
                    inc_pre = (irq_id < cur_q);
                    inc_spu = (irq_id > cur_q);
                    cur_d   = irq_id;
                    svc_d   = RELOAD;
                    state_d = SERVICE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            svc_q   <= 8'd0;
            cur_q   <= 3'd0;
            last_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            svc_q   <= svc_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
        end
    end

    // Saturating statistics; clear has priority over any increment
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            srv_q <= '0;
            pre_q <= '0;
            spu_q <= '0;
        end else if (clr_stats) begin
            srv_q <= '0;
            pre_q <= '0;
            spu_q <= '0;
        end else begin
            if (inc_srv && !(&srv_q)) srv_q <= srv_q + CNT_W'(1);
            if (inc_pre && !(&pre_q)) pre_q <= pre_q + CNT_W'(1);
            if (inc_spu && !(&spu_q)) spu_q <= spu_q + CNT_W'(1);
        end
    end

    assign busy         = (state_q != IDLE);
    assign cur_id       = cur_q;
    assign last_id      = last_q;
    assign serviced_cnt = srv_q;
    assign preempt_cnt  = pre_q;
    assign spurious_cnt = spu_q;

endmodule

// File: tb/tb_ic_irq_servicer.sv
// Bench for ic_irq_servicer: directed handshake scenarios plus a randomized
// run checked cycle by cycle against a behavioural model.
module tb_ic_irq_servicer;

    localparam int SVC  = 4;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rstn, en, irq_out, clr_stats;
    logic [2:0]    irq_id;
    logic          ack, busy;
    logic [2:0]    cur_id, last_id;
    logic [CW-1:0] serviced_cnt, preempt_cnt, spurious_cnt;

    int vec  = 0;
    int miss = 0;

    // behavioural model: phase 0 idle, 1 servicing, 2 waiting to acknowledge
    int m_ph, m_left, m_cur, m_last, m_srv, m_pre, m_spu;
    logic [7:0] pend;

    ic_irq_servicer #(.SVC_CYCLES(SVC), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .en(en), .irq_out(irq_out),
        .irq_id(irq_id), .clr_stats(clr_stats), .ack(ack), .busy(busy),
        .cur_id(cur_id), .last_id(last_id), .serviced_cnt(serviced_cnt),
        .preempt_cnt(preempt_cnt), .spurious_cnt(spurious_cnt)
    );

    always #5 clk = ~clk;

    function automatic int sat(int c);
        return (c < CMAX) ? c + 1 : c;
    endfunction

    function automatic logic m_ack();
        return (m_ph == 2) && irq_out && (int'(irq_id) == m_cur);
    endfunction

    function automatic void m_reset();
        m_ph = 0; m_left = 0; m_cur = 0; m_last = 0;
        m_srv = 0; m_pre = 0; m_spu = 0;
    endfunction

    function automatic void m_retarget(int id);
        if (id < m_cur) m_pre = sat(m_pre);
        else            m_spu = sat(m_spu);
        m_cur  = id;
        m_left = SVC - 1;
        m_ph   = 1;
    endfunction

    function automatic void m_step();
        logic a;
        int   id;
        a  = m_ack();
        id = int'(irq_id);
        if (m_ph == 0) begin
            if (en && irq_out) begin
                m_cur = id; m_left = SVC - 1; m_ph = 1;
            end
        end else if (!irq_out) begin
            m_spu = sat(m_spu); m_ph = 0;
        end else if (m_ph == 2 && a) begin
            m_srv = sat(m_srv); m_last = m_cur; m_ph = 0;
        end else if (id != m_cur) begin
            m_retarget(id);
        end else if (m_left == 0) begin
            m_ph = 2;
        end else begin
            m_left = m_left - 1;
        end
        if (clr_stats) begin
            m_srv = 0; m_pre = 0; m_spu = 0;
        end
    endfunction

    function automatic logic [2:0] lowest(logic [7:0] p);
        logic [2:0] l;
        l = 3'd0;
        for (int i = 7; i >= 0; i--) if (p[i]) l = 3'(i);
        return l;
    endfunction

    task automatic drive(input logic e, input logic i, input logic [2:0] d,
                         input logic c);
        en = e; irq_out = i; irq_id = d; clr_stats = c;
    endtask

    task automatic drive_pend();
        drive(1'b1, |pend, lowest(pend), 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rstn) m_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        m_reset();
        pend = 8'h00;
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vec++;
        if ({ack, busy, cur_id, last_id} !== 8'h00) begin
            miss++;
            $display("FAIL reset_ctl got ack=%b busy=%b cur=%0d last=%0d exp 0",
                     ack, busy, cur_id, last_id);
        end
        vec++;
        if ({serviced_cnt, preempt_cnt, spurious_cnt} !== '0) begin
            miss++;
            $display("FAIL reset_cnt got %0d/%0d/%0d exp 0/0/0",
                     serviced_cnt, preempt_cnt, spurious_cnt);
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            drive(1'b1, c <= 5, 3'd3, 1'b0);
            #1;
            vec++;
            if (ack !== (c == 5)) begin
                miss++;
                $display("FAIL single_ack cyc=%0d got=%b exp=%b", c, ack, c == 5);
            end
            vec++;
            if (busy !== (c >= 1 && c <= 5)) begin
                miss++;
                $display("FAIL single_busy cyc=%0d got=%b exp=%b", c, busy,
                         c >= 1 && c <= 5);
            end
            tick();
        end
        vec++;
        if (cur_id !== 3'd3 || last_id !== 3'd3 || serviced_cnt !== 2'd1) begin
            miss++;
            $display("FAIL single_end got cur=%0d last=%0d srv=%0d exp 3/3/1",
                     cur_id, last_id, serviced_cnt);
        end
    endtask

    // Runs the pending-bit controller model; records the first two acks.
    task automatic run_pend(input int ncyc, input int inj_cyc,
                            input logic [7:0] inj, output int t1,
                            output int id1, output int t2, output int id2);
        logic hit;
        logic [2:0] hid;
        t1 = -1; t2 = -1; id1 = -1; id2 = -1;
        for (int c = 0; c < ncyc; c++) begin
            if (c == inj_cyc) pend = pend | inj;
            drive_pend();
            #1;
            hit = ack;
            hid = irq_id;
            if (hit) begin
                if (t1 < 0) begin t1 = c; id1 = int'(hid); end
                else if (t2 < 0) begin t2 = c; id2 = int'(hid); end
            end
            tick();
            if (hit) pend[hid] = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int t1, id1, t2, id2;
        do_reset();
        pend = 8'b0010_0100;
        run_pend(30, -1, 8'h00, t1, id1, t2, id2);
        vec++;
        if (id1 != 2 || t1 != 5) begin
            miss++;
            $display("FAIL b2b_first got id=%0d cyc=%0d exp id=2 cyc=5", id1, t1);
        end
        vec++;
        if (id2 != 5 || t2 - t1 != 6) begin
            miss++;
            $display("FAIL b2b_second got id=%0d gap=%0d exp id=5 gap=6",
                     id2, t2 - t1);
        end
        vec++;
        if (serviced_cnt !== 2'd2 || last_id !== 3'd5) begin
            miss++;
            $display("FAIL b2b_end got srv=%0d last=%0d exp 2/5",
                     serviced_cnt, last_id);
        end
    endtask

    task automatic test_preempt();
        int t1, id1, t2, id2;
        do_reset();
        pend = 8'b0010_0000;
        run_pend(30, 2, 8'b0000_0010, t1, id1, t2, id2);
        vec++;
        if (id1 != 1 || t1 != 2 + SVC + 1) begin
            miss++;
            $display("FAIL preempt_ack got id=%0d cyc=%0d exp id=1 cyc=%0d",
                     id1, t1, 2 + SVC + 1);
        end
        vec++;
        if (id2 != 5 || t2 != t1 + SVC + 2) begin
            miss++;
            $display("FAIL preempt_resume got id=%0d cyc=%0d exp id=5 cyc=%0d",
                     id2, t2, t1 + SVC + 2);
        end
        vec++;
        if (preempt_cnt !== 2'd1 || serviced_cnt !== 2'd2) begin
            miss++;
            $display("FAIL preempt_cnt got pre=%0d srv=%0d exp 1/2",
                     preempt_cnt, serviced_cnt);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, c < 2, 3'd4, 1'b0);
            #1;
            vec++;
            if (ack !== 1'b0) begin
                miss++;
                $display("FAIL withdraw_ack cyc=%0d got=%b exp=0", c, ack);
            end
            if (c == 3) begin
                vec++;
                if (busy !== 1'b0) begin
                    miss++;
                    $display("FAIL withdraw_idle got busy=%b exp=0", busy);
                end
            end
            tick();
        end
        vec++;
        if (spurious_cnt !== 2'd1 || serviced_cnt !== 2'd0) begin
            miss++;
            $display("FAIL withdraw_cnt got spu=%0d srv=%0d exp 1/0",
                     spurious_cnt, serviced_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drive(1'b1, c <= 5, 3'd6, 1'b0);
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b1, 3'd2, 1'b0);
            tick();
        end
        rstn = 1'b0;
        m_reset();
        #1;
        vec++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            miss++;
            $display("FAIL midrst_ctl got ack=%b busy=%b exp 0/0", ack, busy);
        end
        vec++;
        if (serviced_cnt !== 2'd0 || last_id !== 3'd0 || cur_id !== 3'd0) begin
            miss++;
            $display("FAIL midrst_state got srv=%0d last=%0d cur=%0d exp 0/0/0",
                     serviced_cnt, last_id, cur_id);
        end
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        tick();
        rstn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, c <= 5, 3'd2, 1'b0);
            #1;
            vec++;
            if (ack !== (c == 5)) begin
                miss++;
                $display("FAIL midrst_again cyc=%0d got=%b exp=%b", c, ack, c == 5);
            end
            tick();
        end
        vec++;
        if (serviced_cnt !== 2'd1 || last_id !== 3'd2) begin
            miss++;
            $display("FAIL midrst_end got srv=%0d last=%0d exp 1/2",
                     serviced_cnt, last_id);
        end
    endtask

    task automatic test_saturate_clear();
        int t1, id1, t2, id2;
        logic seen;
        do_reset();
        pend = 8'b1101_1010;
        run_pend(40, -1, 8'h00, t1, id1, t2, id2);
        vec++;
        if (serviced_cnt !== 2'd3 || pend != 8'h00) begin
            miss++;
            $display("FAIL sat_srv got srv=%0d pend=%h exp 3/00",
                     serviced_cnt, pend);
        end
        pend = 8'b0100_0000;
        run_pend(20, 2, 8'b0000_0001, t1, id1, t2, id2);
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, c < 2, 3'd1, 1'b0);
            tick();
        end
        vec++;
        if (preempt_cnt !== 2'd1 || spurious_cnt !== 2'd1) begin
            miss++;
            $display("FAIL sat_pre got pre=%0d spu=%0d exp 1/1",
                     preempt_cnt, spurious_cnt);
        end
        pend = 8'b0000_1000;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            drive_pend();
            #1;
            if (ack) begin
                seen = 1'b1;
                clr_stats = 1'b1;
            end
            tick();
        end
        drive(1'b1, 1'b0, 3'd0, 1'b0);
        #1;
        vec++;
        if (!seen || {serviced_cnt, preempt_cnt, spurious_cnt} !== '0) begin
            miss++;
            $display("FAIL clr_cnt seen=%b got %0d/%0d/%0d exp 0/0/0",
                     seen, serviced_cnt, preempt_cnt, spurious_cnt);
        end
        vec++;
        if (last_id !== 3'd3) begin
            miss++;
            $display("FAIL clr_last got=%0d exp=3", last_id);
        end
    endtask

    task automatic test_random();
        logic       r_irq;
        logic [2:0] r_id;
        do_reset();
        r_irq = 1'b0;
        r_id  = 3'd0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) r_id = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 11) == 0) r_irq = ~r_irq;
            drive($urandom_range(0, 9) != 0, r_irq, r_id,
                  $urandom_range(0, 79) == 0);
            #1;
            vec++;
            if (ack !== m_ack() || busy !== (m_ph != 0)) begin
                miss++;
                $display("FAIL rand_ctl cyc=%0d got ack=%b busy=%b exp %b/%b",
                         c, ack, busy, m_ack(), m_ph != 0);
            end
            vec++;
            if (cur_id !== 3'(m_cur) || last_id !== 3'(m_last)) begin
                miss++;
                $display("FAIL rand_id cyc=%0d got cur=%0d last=%0d exp %0d/%0d",
                         c, cur_id, last_id, m_cur, m_last);
            end
            vec++;
            if (serviced_cnt !== CW'(m_srv) || preempt_cnt !== CW'(m_pre) ||
                spurious_cnt !== CW'(m_spu)) begin
                miss++;
                $display("FAIL rand_cnt cyc=%0d got %0d/%0d/%0d exp %0d/%0d/%0d",
                         c, serviced_cnt, preempt_cnt, spurious_cnt,
                         m_srv, m_pre, m_spu);
            end
            tick();
        end
    endtask

    initial begin
        rstn = 1'b0;
        pend = 8'h00;
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        m_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_preempt();
        test_withdraw();
        test_reset_mid();
        test_saturate_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
